fifo_salida: RTL and testbench

- Output-side FIFO that terminates the arbiter's push interface. It responds to push and pop strobes, stores words, and reports empty, almost_full and full status back to the arbiter.
- The arbiter uses almost_full to decide whether a push to a destination is allowed. The downstream consumer drains the FIFO with pop.
- Four instances sit behind the 4-way arbiter, one per destination 0..3.

---
 rtl/fifo_salida_pkg.sv | 31 +++
 rtl/mem_fifo.sv | 32 +++
 rtl/fifo_salida.sv | 114 +++++++++++
 tb/tb_fifo_salida.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_salida_pkg.sv
// Shared definitions for the output-side FIFOs behind the 4-way arbiter:
// default geometry, status thresholds and the destination encoding.
package fifo_salida_pkg;

  // Default storage geometry: 4 words of 6 bits.
  localparam int unsigned DefDataWidth = 6;
  localparam int unsigned DefAddrWidth = 2;

  // Default status thresholds, in words held.
  localparam int unsigned DefAfullThr  = 3;
  localparam int unsigned DefAemptyThr = 1;

  // One FIFO instance per arbiter destination.
  localparam int unsigned NumDest = 4;

  // Destination encoding shared with the arbiter.
  typedef enum logic [1:0] {
    DestZero  = 2'd0,
    DestOne   = 2'd1,
    DestTwo   = 2'd2,
    DestThree = 2'd3
  } dest_e;

  // True when both thresholds are meaningful for the given depth.
  function automatic bit thr_legal(input int unsigned afull_thr,
                                   input int unsigned aempty_thr,
                                   input int unsigned depth);
    return (afull_thr >= 1) && (afull_thr <= depth) && (aempty_thr <= depth - 1);
  endfunction

endpackage

// File: rtl/mem_fifo.sv
// DEPTH x DATA_WIDTH register-file storage for fifo_salida.
// Synchronous write port, asynchronous (combinational) read port.
module mem_fifo #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  // Contents are don't-care after reset, so the array carries no reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed word on an enabled clock edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port is a plain mux so the owner can register it in one edge.
  always_comb begin
    rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/fifo_salida.sv
// Output-side FIFO terminating one destination of the arbiter's push
// interface. Holds pointers, occupancy, status flags and the sticky error
// flag; storage lives in mem_fifo. Read data is registered (pop -> data in
// one edge) and there is no empty bypass.
module fifo_salida
  import fifo_salida_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned AFULL_THR  = DefAfullThr,
  parameter int unsigned AEMPTY_THR = DefAemptyThr
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error_out
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  // Reject meaningless thresholds while elaborating.
  if (!thr_legal(AFULL_THR, AEMPTY_THR, DEPTH)) begin : g_bad_thr
    $error("fifo_salida: AFULL_THR must be 1..DEPTH and AEMPTY_THR 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;

  logic                  push_ok;
  logic                  pop_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  mem_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Status flags decode straight from the registered occupancy.
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CNT_W'(DEPTH));
    almost_full  = (32'(count_q) >= AFULL_THR);
    almost_empty = (32'(count_q) <= AEMPTY_THR);
  end

  // Accept decisions and next-state for pointers, count, read data and error.
  always_comb begin
    // At full a same-edge pop frees the slot the push needs; at empty the
    // pop is refused even if a push arrives, since there is no bypass.
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop);

    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    data_out_d = pop_ok  ? rd_data : data_out_q;
    valid_d    = pop_ok;

    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    error_d = error_q || (push && !push_ok) || (pop && !pop_ok);
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Drive registered outputs.
  always_comb begin
    data_out  = data_out_q;
    valid_out = valid_q;
    error_out = error_q;
  end

endmodule

// File: tb/tb_fifo_salida.sv
// Self-checking bench for fifo_salida: a queue model of the storage predicts
// accepts, flags and the sticky error; popped words are queued as expected
// results and compared when valid_out shows them.
module tb_fifo_salida;

  localparam int unsigned DW = 6;

  logic          clk;
  logic          reset;
  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic          error_out;

  fifo_salida #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (2),
    .AFULL_THR  (3),
    .AEMPTY_THR (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error_out    (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_tests;
  int unsigned   n_fail;
  logic [DW-1:0] mem_q[$];   // model of stored words
  logic [DW-1:0] exp_q[$];   // scoreboard of expected popped words
  logic          m_err;
  logic          m_valid;
  logic [DW-1:0] m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    int unsigned c;
    c = mem_q.size();
    check({tag, ".empty"},  32'(empty),        32'(c == 0));
    check({tag, ".full"},   32'(full),         32'(c == 4));
    check({tag, ".afull"},  32'(almost_full),  32'(c >= 3));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(c <= 1));
    check({tag, ".error"},  32'(error_out),    32'(m_err));
  endtask

  task automatic model_reset();
    mem_q.delete();
    exp_q.delete();
    m_err   = 1'b0;
    m_valid = 1'b0;
    m_last  = '0;
  endtask

  // One clock: drive strobes, advance the model, then check after the edge.
  task automatic cycle(input string tag, input logic p, input logic [DW-1:0] d, input logic r);
    logic pa, ra;
    push    = p;
    data_in = d;
    pop     = r;
    ra = r && (mem_q.size() > 0);
    pa = p && ((mem_q.size() < 4) || r);
    if (ra) exp_q.push_back(mem_q.pop_front());
    if (pa) mem_q.push_back(d);
    if ((p && !pa) || (r && !ra)) m_err = 1'b1;
    m_valid = ra;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    check({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        check({tag, ".sb_underrun"}, 32'(1), 32'(0));
      end else begin
        m_last = exp_q.pop_front();
        check({tag, ".data"}, 32'(data_out), 32'(m_last));
      end
    end else begin
      check({tag, ".hold"}, 32'(data_out), 32'(m_last));
    end
    check_status(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    model_reset();

    // Reset then idle.
    do_reset();
    check("rst.data", 32'(data_out), 32'(0));
    check("rst.valid", 32'(valid_out), 32'(0));
    check_status("rst");
    cycle("idle", 1'b0, 6'h00, 1'b0);

    // Fill, then overflow.
    cycle("fill1", 1'b1, 6'h11, 1'b0);
    cycle("fill2", 1'b1, 6'h12, 1'b0);
    cycle("fill3", 1'b1, 6'h13, 1'b0);
    cycle("fill4", 1'b1, 6'h14, 1'b0);
    cycle("ovf",   1'b1, 6'h15, 1'b0);

    // Drain in order, then underflow.
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 6'h00, 1'b1);
    cycle("unf", 1'b0, 6'h00, 1'b1);
    cycle("hold", 1'b0, 6'h00, 1'b0);

    // Simultaneous push/pop at full.
    do_reset();
    for (int i = 0; i < 4; i++) cycle("refill", 1'b1, 6'(8'h21 + i), 1'b0);
    cycle("pp_full", 1'b1, 6'h2A, 1'b1);
    for (int i = 0; i < 4; i++) cycle("drain2", 1'b0, 6'h00, 1'b1);

    // Simultaneous push/pop at empty.
    cycle("pp_empty", 1'b1, 6'h05, 1'b1);
    cycle("pop05", 1'b0, 6'h00, 1'b1);

    // Wrap the pointers with push/pop pairs.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle("wrap_push", 1'b1, 6'(8'h30 + i), 1'b0);
      cycle("wrap_pop", 1'b0, 6'h00, 1'b1);
    end

    // Asynchronous reset between edges with valid data showing.
    cycle("pre_a", 1'b1, 6'h3E, 1'b0);
    cycle("pre_b", 1'b1, 6'h3F, 1'b0);
    cycle("pre_pop", 1'b0, 6'h00, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("async.valid", 32'(valid_out), 32'(0));
    check("async.data", 32'(data_out), 32'(0));
    check_status("async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle("post_push", 1'b1, 6'h33, 1'b0);
    cycle("post_pop", 1'b0, 6'h00, 1'b1);

    check("sb_left", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
